// File: rtl/systolic_mem_arbiter_pkg.sv
// Shared types for the systolic memory arbiter: FSM state encoding and
// requester index constants used by the arbiter and its test environment.
package SystolicTypes;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } arb_state_t;

    localparam logic REQ_SYS  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/systolic_mem_arbiter.sv
// Two-requester memory arbiter (systolic controller vs host loader) with burst
// locking, bounded lock under contention, read-valid routing and usage counters.
module systolic_mem_arbiter
    import SystolicTypes::*;
#(
    parameter int WIDTH     = 16,
    parameter int AW        = 12,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [1:0]              we,
    input  logic [1:0]              lock,
    input  logic [AW-1:0]           addr0,
    input  logic [AW-1:0]           addr1,
    input  logic signed [WIDTH-1:0] wdata0,
    input  logic signed [WIDTH-1:0] wdata1,
    output logic [1:0]              gnt,
    output logic signed [WIDTH-1:0] rdata,
    output logic [1:0]              rvalid,
    output logic [AW-1:0]           mem_addr,
    output logic                    mem_we,
    output logic signed [WIDTH-1:0] mem_wdata,
    input  logic signed [WIDTH-1:0] mem_rdata,
    output arb_state_t              arb_state,
    output logic [31:0]             grant_cycles0,
    output logic [31:0]             grant_cycles1,
    output logic [31:0]             contention_count
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t    state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [31:0]   gc0_q, gc0_d, gc1_q, gc1_d, cont_q, cont_d;

    logic owning, own, oth, hold, issue;

    // Tie-break: with both requesting, the one that did not own last wins.
    function automatic logic rr_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return ~last;
        return r[1] ? REQ_HOST : REQ_SYS;
    endfunction

    assign owning = (state_q != ARB_IDLE);
    assign own    = (state_q == OWN1);
    assign oth    = ~own;

    // NOTE: every signal written below gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold         = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) state_d = rr_pick(req, last_owner_q) ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
                hold = req[own] && (!req[oth] || (lock[own] && burst_q != BURST_LAST));
                if (!hold) begin
                    state_d      = req[oth] ? (oth ? OWN1 : OWN0) : ARB_IDLE;
                    last_owner_d = own;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (state_d == ARB_IDLE || state_d != state_q) burst_d = '0;
        else if (burst_q != BURST_LAST)                burst_d = burst_q + 1'b1;
        else                                           burst_d = burst_q;

        gc0_d  = gc0_q  + {31'd0, state_q == OWN0};
        gc1_d  = gc1_q  + {31'd0, state_q == OWN1};
        cont_d = cont_q + {31'd0, owning && req[oth]};
    end

    // Memory port and grant are gated by reset so an aborted burst issues nothing.
    assign issue     = rst && owning && req[own];
    assign mem_addr  = issue ? (own ? addr1 : addr0) : '0;
    assign mem_we    = issue && we[own];
    assign mem_wdata = issue ? (own ? wdata1 : wdata0) : '0;
    assign rvalid_d  = (issue && !we[own]) ? (own ? 2'b10 : 2'b01) : 2'b00;
    assign gnt       = rst ? {state_q == OWN1, state_q == OWN0} : 2'b00;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= REQ_HOST;
            burst_q      <= '0;
            rvalid_q     <= '0;
            gc0_q        <= '0;
            gc1_q        <= '0;
            cont_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_q      <= burst_d;
            rvalid_q     <= rvalid_d;
            gc0_q        <= gc0_d;
            gc1_q        <= gc1_d;
            cont_q       <= cont_d;
        end
    end

    assign rdata            = mem_rdata;
    assign rvalid           = rvalid_q;
    assign arb_state        = state_q;
    assign grant_cycles0    = gc0_q;
    assign grant_cycles1    = gc1_q;
    assign contention_count = cont_q;

endmodule

// File: tb/tb_systolic_mem_arbiter.sv
// Directed bench for systolic_mem_arbiter: reset, single read, round-robin
// handover, bounded lock, host write, lock saturation and mid-burst reset.
module tb_systolic_mem_arbiter;
    import SystolicTypes::*;

    localparam int WIDTH = 16;
    localparam int AW    = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              req, we, lock;
    logic [AW-1:0]           addr0, addr1;
    logic signed [WIDTH-1:0] wdata0, wdata1;
    logic [1:0]              gnt, rvalid;
    logic signed [WIDTH-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]           mem_addr;
    logic                    mem_we;
    arb_state_t              arb_state;
    logic [31:0]             grant_cycles0, grant_cycles1, contention_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    systolic_mem_arbiter #(.WIDTH(WIDTH), .AW(AW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_state(arb_state),
        .grant_cycles0(grant_cycles0), .grant_cycles1(grant_cycles1),
        .contention_count(contention_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state and a single read by the systolic controller
        do_reset();
        check("rst_state", arb_state, ARB_IDLE);
        check("rst_gnt", gnt, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_gc0", grant_cycles0, 0);
        check("rst_gc1", grant_cycles1, 0);
        check("rst_cont", contention_count, 0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 0);

        req = 2'b01; addr0 = 12'h010; #1;
        check("rd_latency_gnt", gnt, 2'b00);
        tick();
        check("rd_gnt", gnt, 2'b01);
        check("rd_addr", mem_addr, 12'h010);
        check("rd_we", mem_we, 1'b0);
        mem_rdata = 16'h1234;
        tick();
        check("rd_rvalid", rvalid, 2'b01);
        check("rd_rdata", {16'h0, rdata}, 32'h1234);
        req = 2'b00; #1;
        check("drop_addr", mem_addr, 0);
        tick();
        check("drop_gnt", gnt, 2'b00);
        check("drop_rvalid", rvalid, 2'b00);
        check("drop_gc0", grant_cycles0, 2);

        // Tie goes to requester 0; dropping req0 hands over without a gap
        do_reset();
        req = 2'b11;
        tick();
        check("tie_gnt", gnt, 2'b01);
        req = 2'b10; we = 2'b01; addr0 = 12'h033; addr1 = 12'h020; #1;
        check("dropped_we", mem_we, 1'b0);
        check("dropped_addr", mem_addr, 0);
        tick();
        check("handover_gnt", gnt, 2'b10);
        check("handover_cont", contention_count, 1);
        check("handover_gc0", grant_cycles0, 1);
        we = 2'b00; #1;
        check("host_rd_addr", mem_addr, 12'h020);
        tick();
        check("host_rvalid", rvalid, 2'b10);
        req = 2'b00;
        tick();
        check("host_done_gnt", gnt, 2'b00);
        check("host_done_gc1", grant_cycles1, 2);
        check("host_done_cont", contention_count, 1);

        // Locked burst bounded to 4 cycles under contention, then a host write
        do_reset();
        req = 2'b11; lock = 2'b01;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("burst_gnt", gnt, 2'b01);
            tick();
        end
        check("burst_release_gnt", gnt, 2'b10);
        check("burst_gc0", grant_cycles0, 4);
        check("burst_cont", contention_count, 4);
        lock = 2'b00; we = 2'b10; addr1 = 12'h100; wdata1 = -16'sd5; #1;
        check("wr_we", mem_we, 1'b1);
        check("wr_addr", mem_addr, 12'h100);
        check("wr_data", {16'h0, mem_wdata}, 32'h0000_FFFB);
        tick();
        check("wr_handover_gnt", gnt, 2'b01);
        check("wr_cont", contention_count, 5);
        check("wr_gc1", grant_cycles1, 1);
        we = 2'b00; #1;
        check("own0_rd_we", mem_we, 1'b0);

        // Uncontended lock lets burst_cnt saturate; contention then releases at once
        req = 2'b01; lock = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sat_gnt", gnt, 2'b01);
        end
        req = 2'b11;
        tick();
        check("sat_release_gnt", gnt, 2'b10);
        check("sat_gc0", grant_cycles0, 11);
        check("sat_cont", contention_count, 6);

        // Reset in the middle of a host read burst
        do_reset();
        req = 2'b10; lock = 2'b10; addr1 = 12'h040;
        tick();
        tick();
        check("hburst_gnt", gnt, 2'b10);
        check("hburst_rvalid", rvalid, 2'b10);
        rst = 1'b0; we = 2'b10; #1;
        check("inrst_gnt", gnt, 2'b00);
        check("inrst_we", mem_we, 1'b0);
        check("inrst_addr", mem_addr, 0);
        tick();
        check("abort_gnt", gnt, 2'b00);
        check("abort_rvalid", rvalid, 2'b00);
        check("abort_gc1", grant_cycles1, 0);
        check("abort_state", arb_state, ARB_IDLE);
        rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b00;
        tick();
        check("post_rst_tie_gnt", gnt, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
